// File: rtl/peri_pwm_fader_pkg.sv
// Shared constants for the PWM fader: register map, control bits and scheduler states.
package peri_pwm_fader_pkg;

    localparam logic [3:0] ADR_PRESC_LO = 4'd8;
    localparam logic [3:0] ADR_PRESC_HI = 4'd9;
    localparam logic [3:0] ADR_STEP     = 4'd10;
    localparam logic [3:0] ADR_STATUS   = 4'd11;
    localparam logic [3:0] ADR_CTRL     = 4'd12;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_SNAP_BIT = 1;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } sched_state_e;

endpackage

// File: rtl/peri_pwm_fader_ramp.sv
// One fader channel: target/current duty registers and clamped step toward target.
module peri_pwm_fader_ramp (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tgt_we_i,
    input  logic [7:0] tgt_dat_i,
    input  logic       tick_i,
    input  logic       snap_i,
    input  logic [7:0] step_i,
    output logic [7:0] cur_o,
    output logic       ramping_o,
    output logic       moved_o
);

    logic [7:0] tgt_q, cur_q, cur_d;
    logic [8:0] step9, diff_up, diff_dn;

    assign ramping_o = (cur_q != tgt_q);
    assign cur_o     = cur_q;

    // 9-bit distances so the clamp compare never wraps; snap takes priority over a tick.
    always_comb begin
        step9   = {1'b0, step_i};
        diff_up = {1'b0, tgt_q} - {1'b0, cur_q};
        diff_dn = {1'b0, cur_q} - {1'b0, tgt_q};
        cur_d   = cur_q;
        if (snap_i) begin
            cur_d = tgt_q;
        end else if (tick_i && ramping_o) begin
            if (tgt_q > cur_q) begin
                cur_d = (step9 >= diff_up) ? tgt_q : cur_q + step_i;
            end else begin
                cur_d = (step9 >= diff_dn) ? tgt_q : cur_q - step_i;
            end
        end
        moved_o = (cur_d != cur_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tgt_q <= 8'h00;
            cur_q <= 8'h00;
        end else begin
            cur_q <= cur_d;
            if (tgt_we_i) begin
                tgt_q <= tgt_dat_i;
            end
        end
    end

endmodule

// File: rtl/peri_pwm_fader.sv
// PWM duty fader: register file, tick prescaler, dirty tracking and round-robin channel writer.
// state | meaning
// IDLE  | no channel write in flight; pick next dirty channel at or after ptr
// REQ   | strobing the selected channel with the latched duty until it acks
module peri_pwm_fader
    import peri_pwm_fader_pkg::*;
#(
    parameter int CHANNELS = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wb_we_i,
    input  logic [3:0]          wb_adr_i,
    input  logic [7:0]          wb_dat_i,
    input  logic                wb_stb_i,
    output logic [7:0]          wb_dat_o,
    output logic                wb_ack_o,
    output logic [CHANNELS-1:0] ch_stb_o,
    output logic                ch_we_o,
    output logic [3:0]          ch_adr_o,
    output logic [7:0]          ch_dat_o,
    input  logic [CHANNELS-1:0] ch_ack_i,
    output logic                busy_o
);

    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SW = IW + 1;

    logic                wr_en, tick, snap;
    logic [15:0]         presc_q, tick_cnt_q;
    logic [7:0]          step_q;
    logic                en_q;
    logic [7:0]          cur [CHANNELS];
    logic [CHANNELS-1:0] ramping, moved, tgt_we, dirty_q, dirty_clr;
    logic [7:0]          status;
    sched_state_e        state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d, ptr_q, ptr_d, rr_idx;
    logic [SW-1:0]       rr_sum;
    logic [7:0]          dat_q, dat_d;
    logic                found;

    assign wr_en    = wb_stb_i & wb_we_i;
    assign wb_ack_o = wb_stb_i;
    assign snap     = wr_en && (wb_adr_i == ADR_CTRL) && wb_dat_i[CTRL_SNAP_BIT];
    assign tick     = en_q && (tick_cnt_q == 16'h0000);

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        assign tgt_we[n] = wr_en && (wb_adr_i == 4'(n));
        peri_pwm_fader_ramp u_ramp (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .tgt_we_i  (tgt_we[n]),
            .tgt_dat_i (wb_dat_i),
            .tick_i    (tick),
            .snap_i    (snap),
            .step_i    (step_q),
            .cur_o     (cur[n]),
            .ramping_o (ramping[n]),
            .moved_o   (moved[n])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= 16'h0000;
            step_q  <= 8'h01;
            en_q    <= 1'b0;
        end else if (wr_en) begin
            case (wb_adr_i)
                ADR_PRESC_LO: presc_q[7:0]  <= wb_dat_i;
                ADR_PRESC_HI: presc_q[15:8] <= wb_dat_i;
                ADR_STEP:     step_q        <= wb_dat_i;
                ADR_CTRL:     en_q          <= wb_dat_i[CTRL_EN_BIT];
                default: ;
            endcase
        end
    end

    // Held at the reload value while disabled so enabling starts a full period.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_cnt_q <= 16'h0000;
        end else if (!en_q || (tick_cnt_q == 16'h0000)) begin
            tick_cnt_q <= presc_q;
        end else begin
            tick_cnt_q <= tick_cnt_q - 16'd1;
        end
    end

    always_comb begin
        status = 8'h00;
        status[CHANNELS-1:0] = ramping;
        wb_dat_o = 8'h00;
        for (int n = 0; n < CHANNELS; n++) begin
            if (wb_adr_i == 4'(n)) wb_dat_o = cur[n];
        end
        case (wb_adr_i)
            ADR_PRESC_LO: wb_dat_o = presc_q[7:0];
            ADR_PRESC_HI: wb_dat_o = presc_q[15:8];
            ADR_STEP:     wb_dat_o = step_q;
            ADR_STATUS:   wb_dat_o = status;
            ADR_CTRL:     wb_dat_o = {7'b0, en_q};
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        dat_d     = dat_q;
        dirty_clr = '0;
        found     = 1'b0;
        rr_sum    = '0;
        rr_idx    = '0;
        case (state_q)
            IDLE: begin
                for (int k = 0; k < CHANNELS; k++) begin
                    rr_sum = {1'b0, ptr_q} + SW'(k);
                    if (rr_sum >= SW'(CHANNELS)) rr_sum = rr_sum - SW'(CHANNELS);
                    rr_idx = rr_sum[IW-1:0];
                    if (!found && dirty_q[rr_idx]) begin
                        found   = 1'b1;
                        idx_d   = rr_idx;
                        dat_d   = cur[rr_idx];
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (ch_ack_i[idx_q]) begin
                    state_d = IDLE;
                    ptr_d   = (idx_q == IW'(CHANNELS - 1)) ? '0 : idx_q + 1'b1;
                    // A value that moved during the transfer must be sent again.
                    if (cur[idx_q] == dat_q) dirty_clr[idx_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            dat_q   <= 8'h00;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            dat_q   <= dat_d;
            dirty_q <= (dirty_q & ~dirty_clr) | moved;
        end
    end

    always_comb begin
        ch_stb_o = '0;
        if (state_q == REQ) ch_stb_o[idx_q] = 1'b1;
    end

    assign ch_we_o  = (state_q == REQ);
    assign ch_adr_o = 4'h0;
    assign ch_dat_o = dat_q;
    assign busy_o   = (|ramping) | (|dirty_q) | (state_q != IDLE);

endmodule

// File: tb/tb_peri_pwm_fader.sv
// Directed bench for peri_pwm_fader: register vector table plus multi-cycle fade/scheduler sequences.
module tb_peri_pwm_fader;

    localparam int CH = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          wb_we_i = 1'b0;
    logic [3:0]    wb_adr_i = 4'h0;
    logic [7:0]    wb_dat_i = 8'h00;
    logic          wb_stb_i = 1'b0;
    logic [7:0]    wb_dat_o;
    logic          wb_ack_o;
    logic [CH-1:0] ch_stb_o;
    logic          ch_we_o;
    logic [3:0]    ch_adr_o;
    logic [7:0]    ch_dat_o;
    logic [CH-1:0] ch_ack_i;
    logic          busy_o;

    peri_pwm_fader #(.CHANNELS(CH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .ch_stb_o(ch_stb_o), .ch_we_o(ch_we_o), .ch_adr_o(ch_adr_o), .ch_dat_o(ch_dat_o),
        .ch_ack_i(ch_ack_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Channel-bank model: acks after ack_delay idle strobe cycles and logs each completed write.
    int ack_delay = 0;
    bit hold_ack  = 1'b0;
    int wait_cnt  = 0;
    int log_ch[$];
    int log_dat[$];

    initial begin
        ch_ack_i = '0;
        forever begin
            @(negedge clk_i);
            ch_ack_i = '0;
            if (ch_stb_o == '0 || !rst_ni) begin
                wait_cnt = 0;
            end else if (!hold_ack) begin
                if (wait_cnt >= ack_delay) begin
                    ch_ack_i = ch_stb_o;
                    for (int c = 0; c < CH; c++) if (ch_stb_o[c]) log_ch.push_back(c);
                    log_dat.push_back(int'(ch_dat_o));
                    check("ch_we", ch_we_o, 1);
                    check("ch_adr", ch_adr_o, 0);
                    check("ch_stb_onehot", $countones(ch_stb_o), 1);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk_i);
        wb_adr_i = a; wb_dat_i = d; wb_we_i = 1'b1; wb_stb_i = 1'b1;
        @(negedge clk_i);
        wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic bus_rd(input string name, input logic [3:0] a, input logic [7:0] exp);
        @(negedge clk_i);
        wb_adr_i = a; wb_we_i = 1'b0; wb_stb_i = 1'b1;
        #1;
        check(name, wb_dat_o, exp);
        check({name, "_ack"}, wb_ack_o, 1);
        wb_stb_i = 1'b0;
    endtask

    task automatic peek(input string name, input logic [3:0] a, input logic [7:0] exp);
        wb_adr_i = a;
        #1;
        check(name, wb_dat_o, exp);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        @(negedge clk_i);
        while (busy_o && k < budget) begin
            @(negedge clk_i);
            k++;
        end
        check(name, busy_o, 0);
    endtask

    task automatic clear_log();
        log_ch.delete();
        log_dat.delete();
    endtask

    typedef int arr4_t[4];
    task automatic check_log(input string name, input int n, input arr4_t ech, input arr4_t edat);
        check({name, "_count"}, log_ch.size(), n);
        for (int i = 0; i < n && i < log_ch.size(); i++) begin
            check($sformatf("%s_ch%0d", name, i), log_ch[i], ech[i]);
            check($sformatf("%s_dat%0d", name, i), log_dat[i], edat[i]);
        end
    endtask

    // Records value changes of a register and the cycle of each change.
    int tv[$];
    int tt[$];
    task automatic track(input logic [3:0] a, input logic [7:0] start, input int n, input int budget);
        logic [7:0] prev = start;
        tv.delete(); tt.delete();
        wb_adr_i = a;
        for (int cyc = 0; cyc < budget && tv.size() < n; cyc++) begin
            @(negedge clk_i);
            #1;
            if (wb_dat_o != prev) begin
                tv.push_back(int'(wb_dat_o));
                tt.push_back(cyc);
                prev = wb_dat_o;
            end
        end
        check("track_changes", tv.size(), n);
    endtask

    task automatic pulse_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        clear_log();
    endtask

    typedef struct {
        bit         wr;
        logic [3:0] adr;
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stb_seen;
        vecs = '{
            '{0, 4'd8,  8'h00, 8'h00}, '{0, 4'd9,  8'h00, 8'h00},
            '{0, 4'd10, 8'h00, 8'h01}, '{0, 4'd11, 8'h00, 8'h00},
            '{0, 4'd12, 8'h00, 8'h00},
            '{1, 4'd8,  8'h34, 8'h00}, '{1, 4'd9,  8'h12, 8'h00},
            '{0, 4'd8,  8'h00, 8'h34}, '{0, 4'd9,  8'h00, 8'h12},
            '{1, 4'd10, 8'h10, 8'h00}, '{0, 4'd10, 8'h00, 8'h10},
            '{1, 4'd13, 8'hff, 8'h00}, '{0, 4'd13, 8'h00, 8'h00},
            '{0, 4'd14, 8'h00, 8'h00}, '{0, 4'd15, 8'h00, 8'h00},
            '{1, 4'd5,  8'haa, 8'h00}, '{0, 4'd5,  8'h00, 8'h00},
            '{0, 4'd7,  8'h00, 8'h00},
            '{1, 4'd12, 8'hff, 8'h00}, '{0, 4'd12, 8'h00, 8'h01},
            '{1, 4'd12, 8'h00, 8'h00}, '{0, 4'd12, 8'h00, 8'h00},
            '{1, 4'd8,  8'h03, 8'h00}, '{1, 4'd9,  8'h00, 8'h00},
            '{0, 4'd8,  8'h00, 8'h03}, '{0, 4'd9,  8'h00, 8'h00},
            '{0, 4'd0,  8'h00, 8'h00}, '{0, 4'd3,  8'h00, 8'h00}
        };

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_stb", ch_stb_o, 0);
        check("rst_busy", busy_o, 0);
        peek("rst_rd_cur0", 4'd0, 8'h00);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_rst_busy", busy_o, 0);

        // Register map vectors
        foreach (vecs[i]) begin
            if (vecs[i].wr) bus_wr(vecs[i].adr, vecs[i].dat);
            else bus_rd($sformatf("vec%0d_adr%0d", i, vecs[i].adr), vecs[i].adr, vecs[i].exp);
        end
        check("regs_no_writes", log_ch.size(), 0);

        // Ramp up: prescaler 3, step 16, target 40
        clear_log();
        bus_wr(4'd12, 8'h01);
        bus_wr(4'd0, 8'd40);
        track(4'd0, 8'd0, 3, 60);
        if (tv.size() == 3) begin
            check("up_v0", tv[0], 16);
            check("up_v1", tv[1], 32);
            check("up_v2", tv[2], 40);
            check("up_gap0", tt[1] - tt[0], 4);
            check("up_gap1", tt[2] - tt[1], 4);
        end
        wait_idle("up_idle", 40);
        check_log("up_log", 3, '{0, 0, 0, 0}, '{16, 32, 40, 0});
        bus_rd("up_status", 4'd11, 8'h00);

        // Ramp down with clamp at the target
        bus_wr(4'd12, 8'h00);
        bus_wr(4'd10, 8'd64);
        bus_wr(4'd1, 8'd200);
        clear_log();
        bus_wr(4'd12, 8'h02);
        wait_idle("snap200_idle", 40);
        check_log("snap200_log", 1, '{1, 0, 0, 0}, '{200, 0, 0, 0});
        bus_rd("snap200_cur1", 4'd1, 8'd200);
        bus_rd("snap200_ctrl", 4'd12, 8'h00);
        clear_log();
        bus_wr(4'd1, 8'd10);
        bus_rd("dn_status", 4'd11, 8'h02);
        bus_wr(4'd12, 8'h01);
        track(4'd1, 8'd200, 3, 60);
        if (tv.size() == 3) begin
            check("dn_v0", tv[0], 136);
            check("dn_v1", tv[1], 72);
            check("dn_v2", tv[2], 10);
        end
        wait_idle("dn_idle", 40);
        check_log("dn_log", 3, '{1, 1, 1, 0}, '{136, 72, 10, 0});
        bus_rd("dn_cur0", 4'd0, 8'd40);
        bus_wr(4'd12, 8'h00);

        // Reset in the middle of a channel-1 transaction
        bus_wr(4'd1, 8'd77);
        clear_log();
        hold_ack = 1'b1;
        bus_wr(4'd12, 8'h02);
        stb_seen = 0;
        for (int k = 0; k < 20 && ch_stb_o != 4'b0010; k++) @(negedge clk_i);
        check("mid_stb_up", ch_stb_o, 4'b0010);
        repeat (2) @(negedge clk_i);
        check("mid_stb_held", ch_stb_o, 4'b0010);
        check("mid_dat", ch_dat_o, 77);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_stb", ch_stb_o, 0);
        check("mid_rst_busy", busy_o, 0);
        peek("mid_rst_cur0", 4'd0, 8'h00);
        peek("mid_rst_cur1", 4'd1, 8'h00);
        peek("mid_rst_status", 4'd11, 8'h00);
        peek("mid_rst_ctrl", 4'd12, 8'h00);
        peek("mid_rst_presc", 4'd8, 8'h00);
        peek("mid_rst_step", 4'd10, 8'h01);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        hold_ack = 1'b0;
        check("mid_log_empty", log_ch.size(), 0);
        clear_log();

        // Round-robin after snap, 3-cycle ack delay
        ack_delay = 3;
        bus_wr(4'd0, 8'd5);
        bus_wr(4'd1, 8'd6);
        bus_wr(4'd2, 8'd7);
        bus_wr(4'd3, 8'd8);
        bus_rd("rr_status", 4'd11, 8'h0f);
        bus_wr(4'd12, 8'h02);
        wait_idle("rr_idle", 100);
        check_log("rr_log", 4, '{0, 1, 2, 3}, '{5, 6, 7, 8});

        // Tick coinciding with a delayed ack
        pulse_reset();
        ack_delay = 3;
        bus_wr(4'd12, 8'h01);
        bus_wr(4'd2, 8'd3);
        wait_idle("toa_idle", 100);
        check_log("toa_log", 2, '{2, 2, 0, 0}, '{1, 3, 0, 0});
        bus_rd("toa_cur2", 4'd2, 8'd3);
        ack_delay = 0;

        // step=0 with enable=0, then snap
        bus_wr(4'd12, 8'h00);
        bus_wr(4'd10, 8'h00);
        bus_wr(4'd3, 8'd100);
        clear_log();
        stb_seen = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (ch_stb_o != '0) stb_seen++;
        end
        check("s0_no_stb", stb_seen, 0);
        check("s0_busy", busy_o, 1);
        bus_rd("s0_cur3", 4'd3, 8'd0);
        bus_rd("s0_status", 4'd11, 8'h08);
        bus_wr(4'd12, 8'h02);
        wait_idle("s0_snap_idle", 40);
        check_log("s0_snap_log", 1, '{3, 0, 0, 0}, '{100, 0, 0, 0});
        bus_rd("s0_cur3_after", 4'd3, 8'd100);
        bus_rd("s0_status_after", 4'd11, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
